// File: rtl/vga_rect_scheduler.sv
// -----------------------------------------------------------------------------
// vga_rect_scheduler
//
// Feeds the write port (x/y/colour/plot) of the 160x120, 3-bit VGA adapter.
// Two rectangle-fill requesters and a full-screen clear share the port.
// One request is accepted at a time in IDLE. Clear has priority. The two
// rectangle requesters alternate (round-robin) when both are asking. The
// granted rectangle is scanned row-major at one pixel per clock. Pixels that
// fall off-screen still use their clock cycle, but plot stays low for them.
//
// Ports
//   CLOCK_50            system clock, everything on the rising edge
//   reset               synchronous, active-high
//   clear_req           full-screen fill with CLEAR_COLOUR
//   clear_ack/done      one-cycle pulses: clear accepted / clear finished
//   req_valid[1:0]      per-requester rectangle request, held until ack
//   req_x0/y0/w/h/colour  packed descriptors, requester 1 in the upper slice
//   req_ack/done[1:0]   one-cycle pulses: descriptor latched / rect finished
//   busy                high in every state except IDLE
//   x, y, colour, plot  adapter write port (all registered)
// -----------------------------------------------------------------------------
module vga_rect_scheduler #(
  parameter int                  SCREEN_W     = 160,
  parameter int                  SCREEN_H     = 120,
  parameter int                  COLOUR_W     = 3,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  clear_req,
  output logic                  clear_ack,
  output logic                  clear_done,
  input  logic [1:0]            req_valid,
  input  logic [15:0]           req_x0,
  input  logic [13:0]           req_y0,
  input  logic [15:0]           req_w,
  input  logic [13:0]           req_h,
  input  logic [2*COLOUR_W-1:0] req_colour,
  output logic [1:0]            req_ack,
  output logic [1:0]            req_done,
  output logic                  busy,
  output logic [7:0]            x,
  output logic [6:0]            y,
  output logic [COLOUR_W-1:0]   colour,
  output logic                  plot
);

  // The scan counters are one bit wider than a descriptor coordinate, so
  // x0+w-1 and y0+h-1 never wrap.
  localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);
  localparam logic [7:0] CLEAR_W = 8'(SCREEN_W);
  localparam logic [6:0] CLEAR_H = 7'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
  // Records who owns the current job, so the done pulse goes to that owner.
  typedef enum logic [1:0] {OWN_R0, OWN_R1, OWN_CLEAR} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [7:0]          x0_q, x0_d;
  logic [8:0]          x_end_q, x_end_d;
  logic [7:0]          y_end_q, y_end_d;
  logic [COLOUR_W-1:0] fill_q, fill_d;
  logic [8:0]          cx_q, cx_d;
  logic [7:0]          cy_q, cy_d;

  logic [7:0]          x_d;
  logic [6:0]          y_d;
  logic [COLOUR_W-1:0] colour_d;
  logic                plot_d, busy_d, clear_ack_d, clear_done_d;
  logic [1:0]          req_ack_d, req_done_d;
  logic                fire_done;

  function automatic logic on_screen(input logic [8:0] px, input logic [7:0] py);
    return (px < X_LIMIT) && (py < Y_LIMIT);
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration and descriptor selection. Only IDLE uses these results.
  // ---------------------------------------------------------------------------
  logic                grant_idx;
  logic [7:0]          start_x0, start_w;
  logic [6:0]          start_y0, start_h;
  logic [COLOUR_W-1:0] start_colour;

  always_comb begin
    // If both requesters ask, the one that did not win last time is granted.
    grant_idx = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    if (clear_req) begin
      start_x0     = '0;
      start_y0     = '0;
      start_w      = CLEAR_W;
      start_h      = CLEAR_H;
      start_colour = CLEAR_COLOUR;
    end else begin
      start_x0     = grant_idx ? req_x0[15:8] : req_x0[7:0];
      start_y0     = grant_idx ? req_y0[13:7] : req_y0[6:0];
      start_w      = grant_idx ? req_w[15:8]  : req_w[7:0];
      start_h      = grant_idx ? req_h[13:7]  : req_h[6:0];
      start_colour = grant_idx ? req_colour[2*COLOUR_W-1:COLOUR_W]
                               : req_colour[COLOUR_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. Every output is computed here one cycle
  // ahead and registered below.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: each variable gets a default before the case. Without it, a path
    // that skips an assignment would infer a latch.
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    x0_d         = x0_q;
    x_end_d      = x_end_q;
    y_end_d      = y_end_q;
    fill_d       = fill_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    x_d          = x;
    y_d          = y;
    colour_d     = colour;
    plot_d       = 1'b0;
    clear_ack_d  = 1'b0;
    clear_done_d = 1'b0;
    req_ack_d    = '0;
    req_done_d   = '0;
    fire_done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clear_req || (|req_valid)) begin
          if (clear_req) begin
            // A clear grant leaves the round-robin pointer unchanged.
            owner_d     = OWN_CLEAR;
            clear_ack_d = 1'b1;
          end else begin
            owner_d              = grant_idx ? OWN_R1 : OWN_R0;
            last_grant_d         = grant_idx;
            req_ack_d[grant_idx] = 1'b1;
          end
          x0_d    = start_x0;
          x_end_d = {1'b0, start_x0} + {1'b0, start_w} - 9'd1;
          y_end_d = {1'b0, start_y0} + {1'b0, start_h} - 8'd1;
          fill_d  = start_colour;
          cx_d    = {1'b0, start_x0};
          cy_d    = {1'b0, start_y0};
          if (start_w == '0 || start_h == '0) begin
            state_d = DONE;
          end else begin
            // The first pixel goes out together with the ack.
            state_d  = DRAW;
            x_d      = start_x0;
            y_d      = start_y0;
            colour_d = start_colour;
            plot_d   = on_screen(cx_d, cy_d);
          end
        end
      end

      DRAW: begin
        // cx_q/cy_q hold the pixel that is on the port during this cycle.
        if (cx_q == x_end_q && cy_q == y_end_q) begin
          state_d   = DONE;
          fire_done = 1'b1;
        end else begin
          if (cx_q == x_end_q) begin
            cx_d = {1'b0, x0_q};
            cy_d = cy_q + 8'd1;
          end else begin
            cx_d = cx_q + 9'd1;
          end
          x_d      = cx_d[7:0];
          y_d      = cy_d[6:0];
          colour_d = fill_q;
          plot_d   = on_screen(cx_d, cy_d);
        end
      end

      DONE: begin
        // If DRAW sent us here, the done pulse is already on the port. A
        // zero-size job comes straight from IDLE and sends its pulse now,
        // which keeps ack and done in separate cycles.
        if (clear_done || (|req_done)) state_d = IDLE;
        else                           fire_done = 1'b1;
      end

      default: state_d = IDLE;
    endcase

    if (fire_done) begin
      case (owner_q)
        OWN_CLEAR: clear_done_d  = 1'b1;
        OWN_R1:    req_done_d[1] = 1'b1;
        default:   req_done_d[0] = 1'b1;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers. Reset abandons any job in flight without
  // sending its done pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignment only. Then every
    // register samples values from before the edge, whatever the order of
    // the statements.
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_R0;
      last_grant_q <= 1'b1;
      x0_q         <= '0;
      x_end_q      <= '0;
      y_end_q      <= '0;
      fill_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      x            <= '0;
      y            <= '0;
      colour       <= '0;
      plot         <= 1'b0;
      busy         <= 1'b0;
      clear_ack    <= 1'b0;
      clear_done   <= 1'b0;
      req_ack      <= '0;
      req_done     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      x0_q         <= x0_d;
      x_end_q      <= x_end_d;
      y_end_q      <= y_end_d;
      fill_q       <= fill_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      x            <= x_d;
      y            <= y_d;
      colour       <= colour_d;
      plot         <= plot_d;
      busy         <= busy_d;
      clear_ack    <= clear_ack_d;
      clear_done   <= clear_done_d;
      req_ack      <= req_ack_d;
      req_done     <= req_done_d;
    end
  end

endmodule

// File: tb/tb_vga_rect_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vga_rect_scheduler
//
// Scoreboard bench for vga_rect_scheduler. When a request is driven, the
// bench pushes the pixels it expects (after clipping) and the ack/done events
// it expects onto queues. Each event carries the cycle gap expected since the
// previous event. A monitor samples on the falling edge and checks every
// plotted pixel and every ack/done pulse against the heads of those queues.
// -----------------------------------------------------------------------------
module tb_vga_rect_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic        clear_req = 1'b0;
  logic        clear_ack, clear_done;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_x0 = '0;
  logic [13:0] req_y0 = '0;
  logic [15:0] req_w  = '0;
  logic [13:0] req_h  = '0;
  logic [5:0]  req_colour = '0;
  logic [1:0]  req_ack, req_done;
  logic        busy;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot;

  vga_rect_scheduler dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_ack  (clear_ack),
    .clear_done (clear_done),
    .req_valid  (req_valid),
    .req_x0     (req_x0),
    .req_y0     (req_y0),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .req_ack    (req_ack),
    .req_done   (req_done),
    .busy       (busy),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Event bit layout: {clear_ack, clear_done, req_ack[1:0], req_done[1:0]}
  localparam logic [5:0] EV_CLR_ACK  = 6'b100000;
  localparam logic [5:0] EV_CLR_DONE = 6'b010000;
  localparam logic [5:0] EV_ACK1     = 6'b001000;
  localparam logic [5:0] EV_ACK0     = 6'b000100;
  localparam logic [5:0] EV_DONE1    = 6'b000010;
  localparam logic [5:0] EV_DONE0    = 6'b000001;
  localparam logic [5:0] EV_ANY_DONE = 6'b010011;

  typedef struct {
    logic [5:0] ev;
    int         gap;   // cycles since previous event, -1 = unchecked
  } ev_t;

  logic [17:0] pix_q[$];   // {x, y, colour}
  ev_t         ev_q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ev_cyc = 0;
  int busy_chk_cyc = -1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, halfway between active edges.
  always @(negedge CLOCK_50) begin
    logic [5:0] seen;
    ev_t        e;
    seen = {clear_ack, clear_done, req_ack, req_done};
    if (plot) begin
      check("pixel_expected", pix_q.size() > 0, 1);
      if (pix_q.size() > 0) check("pixel", {x, y, colour}, pix_q.pop_front());
    end
    if (seen != '0) begin
      check("event_expected", ev_q.size() > 0, 1);
      if (ev_q.size() > 0) begin
        e = ev_q.pop_front();
        check("event", seen, e.ev);
        if (e.gap >= 0) check("event_gap", cyc - last_ev_cyc, e.gap);
      end
      last_ev_cyc = cyc;
      if ((seen & EV_ANY_DONE) != '0) busy_chk_cyc = cyc + 1;
    end
    if (cyc == busy_chk_cyc) check("busy_after_done", busy, 0);
  end

  task automatic push_ev(input logic [5:0] ev, input int gap);
    ev_t e;
    e.ev  = ev;
    e.gap = gap;
    ev_q.push_back(e);
  endtask

  // Expected plotted pixels of a rectangle, row-major, with clipping.
  task automatic push_rect(input int x0, input int y0, input int w, input int h,
                           input logic [2:0] c);
    for (int r = 0; r < h; r++) begin
      for (int q = 0; q < w; q++) begin
        int px;
        int py;
        px = x0 + q;
        py = y0 + r;
        if (px < 160 && py < 120) pix_q.push_back({px[7:0], py[6:0], c});
      end
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] x0, input logic [6:0] y0,
                         input logic [7:0] w, input logic [6:0] h, input logic [2:0] c);
    req_x0[8*i +: 8]     = x0;
    req_y0[7*i +: 7]     = y0;
    req_w[8*i +: 8]      = w;
    req_h[7*i +: 7]      = h;
    req_colour[3*i +: 3] = c;
  endtask

  // Waits (bounded) for any of the masked ack/done bits. Returns at the
  // falling edge where one of them is seen.
  task automatic wait_for(input logic [5:0] mask, input int budget, input string tag);
    int   n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge CLOCK_50);
      n++;
      hit = (({clear_ack, clear_done, req_ack, req_done} & mask) != '0);
    end
    check(tag, hit, 1);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    clear_req = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge CLOCK_50);
    check("reset_outputs",
          {plot, busy, clear_ack, clear_done, req_ack, req_done, x, y, colour}, 0);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // 1: basic 3x2 rectangle on requester 0.
    do_reset();
    set_req(0, 8'd10, 7'd20, 8'd3, 7'd2, 3'b101);
    push_rect(10, 20, 3, 2, 3'b101);
    push_ev(EV_ACK0, -1);
    push_ev(EV_DONE0, 6);
    req_valid = 2'b01;
    wait_for(EV_ACK0, 10, "t1_ack");
    req_valid = 2'b00;
    wait_for(EV_DONE0, 20, "t1_done");
    repeat (3) @(negedge CLOCK_50);
    check("t1_pixels_left", pix_q.size(), 0);

    // 2: both requesters held after reset, so grants go 0,1,0,1 with the
    // next ack 2 cycles after the previous done.
    do_reset();
    set_req(0, 8'd5, 7'd5, 8'd1, 7'd1, 3'b001);
    set_req(1, 8'd6, 7'd6, 8'd1, 7'd1, 3'b010);
    for (int k = 0; k < 2; k++) begin
      push_rect(5, 5, 1, 1, 3'b001);
      push_rect(6, 6, 1, 1, 3'b010);
      push_ev(EV_ACK0, (k == 0) ? -1 : 2);
      push_ev(EV_DONE0, 1);
      push_ev(EV_ACK1, 2);
      push_ev(EV_DONE1, 1);
    end
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) wait_for(EV_ACK0 | EV_ACK1, 20, "t2_ack");
    req_valid = 2'b00;
    wait_for(EV_DONE1, 10, "t2_done");
    repeat (3) @(negedge CLOCK_50);
    check("t2_pixels_left", pix_q.size(), 0);

    // 3: clipping at the bottom-right corner. 16 cycles, 4 plotted.
    set_req(0, 8'd158, 7'd118, 8'd4, 7'd4, 3'b110);
    push_rect(158, 118, 4, 4, 3'b110);
    push_ev(EV_ACK0, -1);
    push_ev(EV_DONE0, 16);
    req_valid = 2'b01;
    wait_for(EV_ACK0, 10, "t3_ack");
    req_valid = 2'b00;
    wait_for(EV_DONE0, 40, "t3_done");
    repeat (3) @(negedge CLOCK_50);
    check("t3_pixels_left", pix_q.size(), 0);

    // 4: clear and rectangle in the same cycle. Clear wins, then the held
    // rectangle follows.
    set_req(0, 8'd1, 7'd2, 8'd2, 7'd1, 3'b011);
    push_rect(0, 0, 160, 120, 3'b000);
    push_rect(1, 2, 2, 1, 3'b011);
    push_ev(EV_CLR_ACK, -1);
    push_ev(EV_CLR_DONE, 19200);
    push_ev(EV_ACK0, 2);
    push_ev(EV_DONE0, 2);
    clear_req = 1'b1;
    req_valid = 2'b01;
    wait_for(EV_CLR_ACK, 10, "t4_clear_ack");
    clear_req = 1'b0;
    wait_for(EV_ACK0, 19300, "t4_rect_ack");
    req_valid = 2'b00;
    wait_for(EV_DONE0, 10, "t4_done");
    repeat (3) @(negedge CLOCK_50);
    check("t4_pixels_left", pix_q.size(), 0);

    // 5: zero-width request. Ack then done, no plot.
    set_req(1, 8'd20, 7'd30, 8'd0, 7'd5, 3'b111);
    push_ev(EV_ACK1, -1);
    push_ev(EV_DONE1, 1);
    req_valid = 2'b10;
    wait_for(EV_ACK1, 10, "t5_ack");
    req_valid = 2'b00;
    wait_for(EV_DONE1, 10, "t5_done");
    repeat (3) @(negedge CLOCK_50);
    check("t5_busy_idle", busy, 0);

    // 6: reset 15 pixels into a 10x10 draw on requester 0, then a tie that
    // requester 0 must win again.
    set_req(0, 8'd0, 7'd0, 8'd10, 7'd10, 3'b111);
    push_rect(0, 0, 10, 1, 3'b111);
    push_rect(0, 1, 5, 1, 3'b111);
    push_ev(EV_ACK0, -1);
    req_valid = 2'b01;
    wait_for(EV_ACK0, 10, "t6_ack");
    req_valid = 2'b00;
    repeat (14) @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    check("t6_after_reset", {plot, busy, clear_done, req_done}, 0);
    reset = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    check("t6_pixels_left", pix_q.size(), 0);

    set_req(0, 8'd3, 7'd4, 8'd1, 7'd1, 3'b001);
    set_req(1, 8'd7, 7'd8, 8'd1, 7'd1, 3'b100);
    push_rect(3, 4, 1, 1, 3'b001);
    push_rect(7, 8, 1, 1, 3'b100);
    push_ev(EV_ACK0, -1);
    push_ev(EV_DONE0, 1);
    push_ev(EV_ACK1, 2);
    push_ev(EV_DONE1, 1);
    req_valid = 2'b11;
    wait_for(EV_ACK0 | EV_ACK1, 10, "t6_tie_ack");
    req_valid = 2'b10;
    wait_for(EV_ACK1, 10, "t6_second_ack");
    req_valid = 2'b00;
    wait_for(EV_DONE1, 10, "t6_done");
    repeat (3) @(negedge CLOCK_50);

    check("final_pixels_left", pix_q.size(), 0);
    check("final_events_left", ev_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
